ser_rx: RTL
===========

Name: ser_rx

Overview:
- Serial-to-parallel receiver: the receiving end of the parallel-load/shift-out serializer link.
- Collects a framed bit stream (data, bit strobe, frame start) into a size-bit word.
- Presents the word on a registered valid/ready output port.
- Sits between an off-block serial link and word-wide datapath logic such as a register file or FIFO.

Parameters:
- size, 32, word width in bits; legal range is 2 or more.
- msb_first, 1, bit order. 1 = first bit received lands in q[size-1], matching a left-shifting serializer. 0 = first bit lands in q[0].

Ports:
- clk  in  1  clock; all logic on posedge.
- r  in  1  reset; synchronous, active-low (r=0 at posedge resets).
- sd  in  1  serial data bit; sampled only when sv=1.
- sv  in  1  bit strobe; one bit is transferred per cycle with sv=1.
- sf  in  1  frame start; qualified by sv; marks the first bit of a word.
- q  out  size  received word.
- q_valid  out  1  q holds an unconsumed word.
- q_ready  in  1  consumer accepts q this cycle.
- busy  out  1  a frame is in progress (state != IDLE).
- ovr  out  1  sticky overrun flag.
- ferr  out  1  sticky framing-error flag.
- clr  in  1  clears the sticky flags.

Behaviour:
- Reset: r=0 at posedge forces state=IDLE, bit count=0, shift reg=0, q=0, q_valid=0, ovr=0, ferr=0 (and perr=0). Reset overrides all other inputs. A reset mid-frame discards the partial word.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- IDLE:
  - sv&sf: load sd as bit 0 of the frame, count=1, go to SHIFT.
  - sv without sf: ignored.
- SHIFT:
  - Each sv&!sf shifts sd in and increments count.
  - msb_first=1: shift left, insert at LSB. msb_first=0: shift right, insert at MSB.
  - When count==size-1 and sv: word is complete. Commit it (or go to PARITY if enabled), then go to IDLE.
  - sv&sf in SHIFT: set ferr, discard the partial word, restart with sd as the first bit (count=1, stay in SHIFT).
- Cycles with sv=0 stall with no state change. There is no timeout.
- Commit:
  - If q_valid=0, or q_valid&q_ready in the same cycle: q<=word, q_valid<=1.
  - Otherwise: word is dropped, ovr<=1, q unchanged.
- Output handshake:
  - Transfer occurs on q_valid&q_ready at posedge; q_valid then clears unless a commit occurs in that same cycle, which keeps it at 1 with the new q.
  - q is stable while q_valid=1.
- Latency: q_valid rises at the posedge that samples the last data bit, so it is visible in the cycle after the last bit is presented.
- Sticky flags: clr=1 clears ovr/ferr/perr. A set event in the same cycle wins over clr.
- Counter width is clog2(size)+1. Count never exceeds size-1 before wrapping to IDLE.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - Output port perr (1 bit, sticky, reset 0, cleared by clr) exists.
  - After the last data bit, the FSM enters PARITY and waits for one more sv bit (even parity: XOR of all data bits and the parity bit must equal 0).
  - Match: commit as above.
  - Mismatch: set perr, drop the word; no q_valid, no ovr.
  - sv&sf in PARITY: set ferr and restart as in SHIFT.
- Undefined: no PARITY state, no perr port; the word commits directly from SHIFT.

Test Plan:
- Reset: r=0 for 2 cycles while sv=1, sf=1, sd toggling -> q=0, q_valid=0, busy=0, ovr=0, ferr=0; no frame is started.
- Basic frame: size=32, msb_first=1, q_ready=1, send 0xDEADBEEF MSB first, sf on bit 0, sv=1 every cycle -> q_valid=1 for exactly 1 cycle after the 32nd bit, q=0xDEADBEEF, busy low after commit. Repeat with msb_first=0, sending LSB first -> same q.
- Backpressure/overrun: q_ready=0, send 0xA5A5A5A5 then 0x12345678 -> q stays 0xA5A5A5A5, ovr=1; then q_ready=1 -> exactly one transfer, q_valid drops. Pulse clr -> ovr=0.
- Framing: start a frame, assert sf on bit 10, then send 32 bits of 0x0000FFFF -> ferr=1, q=0x0000FFFF, one q_valid.
- Stalls and reset: random sv gaps within 0x13579BDF -> q=0x13579BDF. Apply r=0 at bit 16 of a frame -> no q_valid; the next full frame 0xCAFEF00D is received correctly.
- Parity (SER_PARITY_EN): 0x00000001 with parity bit 1 -> accepted, q_valid=1. Same word with parity bit 0 -> perr=1, no q_valid, ovr=0.

Source files
------------

// File: rtl/ser_rx_if.sv
// Word-side handshake bundle for the serial receiver.
// master drives q/q_valid, slave returns q_ready.
interface ser_rx_if #(
  parameter int size = 32
);
  logic [size-1:0] q;
  logic            q_valid;
  logic            q_ready;

  modport master (
    output q,
    output q_valid,
    input  q_ready
  );

  modport slave (
    input  q,
    input  q_valid,
    output q_ready
  );
endinterface

// File: rtl/ser_rx.sv
// Serial-to-parallel receiver with registered valid/ready word output.
// Define SER_PARITY_EN to add an even-parity bit per frame and the perr flag.
module ser_rx #(
  parameter int size      = 32,
  parameter bit msb_first = 1'b1
) (
  input  logic     clk,
  input  logic     r,
  input  logic     sd,
  input  logic     sv,
  input  logic     sf,
  input  logic     clr,
  ser_rx_if.master qo,
  output logic     busy,
  output logic     ovr,
`ifdef SER_PARITY_EN
  output logic     perr,
`endif
  output logic     ferr
);

  localparam int CW = $clog2(size) + 1;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t          st, st_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [size-1:0] sr, sr_n, word;
  logic            commit;
  logic            ferr_set;
  logic            ovr_set;
`ifdef SER_PARITY_EN
  logic            perr_set;
`endif

  function automatic logic [size-1:0] ins(
    input logic [size-1:0] v,
    input logic            b
  );
    if (msb_first) return {v[size-2:0], b};
    else           return {b, v[size-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!r) st <= IDLE;
    else    st <= st_n;
  end

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    sr_n     = sr;
    word     = ins(sr, sd);
    commit   = 1'b0;
    ferr_set = 1'b0;
`ifdef SER_PARITY_EN
    perr_set = 1'b0;
`endif
    unique case (st)
      IDLE: begin
        if (sv && sf) begin
          sr_n  = ins('0, sd);
          cnt_n = CW'(1);
          st_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (sv && sf) begin
          ferr_set = 1'b1;
          sr_n     = ins('0, sd);
          cnt_n    = CW'(1);
        end else if (sv && cnt == CW'(size - 1)) begin
          sr_n  = word;
          cnt_n = '0;
`ifdef SER_PARITY_EN
          st_n  = PARITY;
`else
          st_n   = IDLE;
          commit = 1'b1;
`endif
        end else if (sv) begin
          sr_n  = word;
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        word = sr;
        if (sv && sf) begin
          ferr_set = 1'b1;
          sr_n     = ins('0, sd);
          cnt_n    = CW'(1);
          st_n     = SHIFT;
        end else if (sv) begin
          st_n = IDLE;
          // even parity: data bits plus parity bit must xor to zero
          if (^{sr, sd}) perr_set = 1'b1;
          else           commit   = 1'b1;
        end
      end
`endif
      default: st_n = IDLE;
    endcase
    ovr_set = commit & qo.q_valid & ~qo.q_ready;
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      cnt        <= '0;
      sr         <= '0;
      qo.q       <= '0;
      qo.q_valid <= 1'b0;
      ovr        <= 1'b0;
      ferr       <= 1'b0;
`ifdef SER_PARITY_EN
      perr       <= 1'b0;
`endif
    end else begin
      cnt <= cnt_n;
      sr  <= sr_n;
      if (commit && (!qo.q_valid || qo.q_ready)) begin
        qo.q       <= word;
        qo.q_valid <= 1'b1;
      end else if (qo.q_valid && qo.q_ready) begin
        qo.q_valid <= 1'b0;
      end
      ovr  <= ovr_set | (ovr & ~clr);
      ferr <= ferr_set | (ferr & ~clr);
`ifdef SER_PARITY_EN
      perr <= perr_set | (perr & ~clr);
`endif
    end
  end

  assign busy = (st != IDLE);

endmodule
